vga_sink_decoder: RTL and testbench
===================================

VGA_SINK_DECODER -- requirements
Module: vga_sink_decoder

Interface
REQ-001 Parameters SHALL be: H_TOTAL, default 800, pixel clocks per line; V_TOTAL, default 525, lines per frame; H_START, default 144, first active hcnt; V_START, default 35, first active vcnt; WIDTH, default 640, active pixels per line; HEIGHT, default 480, active lines.
REQ-002 Ports SHALL be as follows, with clock and reset first.
  clk  in  1  100 MHz system clock, only clock
  reset  in  1  synchronous, active-high
  pix_en  in  1  one-cycle pixel strobe (1 of every 4 clk)
  hSync  in  1  horizontal sync, active-low
  vSync  in  1  vertical sync, active-low
  VGA_R/VGA_G/VGA_B  in  4 each  colour under test
  probe_x  in  10  pixel column to capture
  probe_y  in  9  pixel row to capture
  locked  out  1  timing verified
  active  out  1  current sample inside visible area
  x  out  10  column of current sample
  y  out  9  row of current sample
  frame_start  out  1  one-clk pulse on vSync falling edge
  sync_error  out  1  one-clk pulse on timing violation
  probe_rgb  out  12  captured {R,G,B} at probe position
  probe_valid  out  1  one-clk pulse when probe_rgb updates
  checksum  out  16  last complete frame checksum

Function
REQ-003 All inputs except reset SHALL be sampled only on clk edges where pix_en=1; no other cycle changes any state.
REQ-004 Sync falling edges SHALL be detected against the previous pix_en sample of the same signal.
REQ-005 hcnt (10 bit) SHALL be loaded with 0 on an hSync falling-edge sample, else increment by 1 each sample.
REQ-006 vcnt (10 bit) SHALL be loaded with 0 on a vSync falling-edge sample; else it SHALL increment on an hSync falling-edge sample; a vSync edge wins when both coincide.
REQ-007 active SHALL be 1 iff locked=1, H_START<=hcnt<H_START+WIDTH and V_START<=vcnt<V_START+HEIGHT; x=hcnt-H_START, y=vcnt-V_START when active, else x=0, y=0.
REQ-008 x, y, active SHALL be registered and valid on the clk cycle after the pix_en sample that produced them.
REQ-009 FSM states SHALL be SEARCH, ACQUIRE, LOCKED. SEARCH->ACQUIRE on a vSync falling edge; ACQUIRE->LOCKED on the next vSync falling edge with no violation; any violation in ACQUIRE or LOCKED -> SEARCH.
REQ-010 Violations SHALL be: an hSync edge with hcnt!=H_TOTAL-1; a vSync edge with vcnt!=V_TOTAL-1; hcnt reaching H_TOTAL without an hSync edge. Violations are checked only in ACQUIRE and LOCKED.
REQ-011 locked SHALL be 1 only in LOCKED; sync_error SHALL pulse for one clk per violation, on the cycle after the violating sample.
REQ-012 frame_start SHALL pulse for one clk after every vSync falling-edge sample, in any state.
REQ-013 When active and (x,y)==(probe_x,probe_y), probe_rgb SHALL load {VGA_R,VGA_G,VGA_B} and probe_valid SHALL pulse on the following clk; an out-of-range probe never fires.
REQ-014 probe_x/probe_y changes SHALL take effect on the next pix_en sample.

Reset
REQ-015 When reset=1 at a clk edge: FSM=SEARCH; hcnt, vcnt, x, y, probe_rgb, checksum, internal accumulator =0; active, locked, frame_start, sync_error, probe_valid =0; previous-sync registers =1.
REQ-016 Reset SHALL take priority over pix_en; reset mid-frame discards all partial measurement.

Configuration
REQ-017 With VGA_SINK_CHECKSUM_EN defined: each active sample SHALL update acc <= {acc[14:0],acc[15]} ^ {4'h0,R,G,B}; on each vSync falling edge while LOCKED, checksum <= acc and acc <= 0.
REQ-018 Without VGA_SINK_CHECKSUM_EN: checksum SHALL be constant 0 and no accumulator logic is present.

Verification
REQ-019 Two ideal 800x525 frames, hSync low hcnt 0-95, vSync low lines 0-1 -> locked=1 after the second vSync edge, sync_error never pulses.
REQ-020 Locked; one line of 799 samples -> a single sync_error pulse, locked=0, FSM SEARCH, relock after two good frames.
REQ-021 Locked; probe=(639,479), RGB=12'hABC at that pixel only -> probe_valid pulses once per frame, probe_rgb=12'hABC.
REQ-022 Locked; first active sample -> x=0,y=0,active=1 one clk after pix_en at hcnt=144,vcnt=35; hcnt=784 -> active=0.
REQ-023 CHECKSUM_EN; two frames all pixels 12'h000 -> checksum=16'h0000; frame with only pixel (0,0)=12'h001 -> checksum=16'h0001 rotated 307199 times = 16'h8000.
REQ-024 reset asserted at hcnt=400 mid-frame -> next clk all outputs 0, FSM SEARCH, no frame_start until next vSync edge.

Source files
------------

// File: rtl/vga_sink_decoder.sv
// VGA sink: samples sync/colour on pix_en strobes, verifies timing, tracks pixel coordinates
// and captures one probed pixel. Define VGA_SINK_CHECKSUM_EN to add a per-frame checksum.
module vga_sink_decoder #(
   parameter int unsigned H_TOTAL = 800,
   parameter int unsigned V_TOTAL = 525,
   parameter int unsigned H_START = 144,
   parameter int unsigned V_START = 35,
   parameter int unsigned WIDTH   = 640,
   parameter int unsigned HEIGHT  = 480
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pix_en,
   input  logic        hSync,
   input  logic        vSync,
   input  logic [3:0]  VGA_R,
   input  logic [3:0]  VGA_G,
   input  logic [3:0]  VGA_B,
   input  logic [9:0]  probe_x,
   input  logic [8:0]  probe_y,
   output logic        locked,
   output logic        active,
   output logic [9:0]  x,
   output logic [8:0]  y,
   output logic        frame_start,
   output logic        sync_error,
   output logic [11:0] probe_rgb,
   output logic        probe_valid,
   output logic [15:0] checksum
);

   localparam logic [9:0] HLast   = 10'(H_TOTAL - 1);
   localparam logic [9:0] VLast   = 10'(V_TOTAL - 1);
   localparam logic [9:0] HBegin  = 10'(H_START);
   localparam logic [9:0] HEnd    = 10'(H_START + WIDTH);
   localparam logic [9:0] VBegin  = 10'(V_START);
   localparam logic [9:0] VEnd    = 10'(V_START + HEIGHT);
   localparam logic [8:0] YOffset = 9'(V_START);

   typedef enum logic [1:0] {StSearch, StAcquire, StLocked} state_e;

   state_e      state_q, state_d;
   logic [9:0]  hcnt_q, hcnt_d;
   logic [9:0]  vcnt_q, vcnt_d;
   logic        hs_prev_q, hs_prev_d;
   logic        vs_prev_q, vs_prev_d;
   logic        active_q, active_d;
   logic [9:0]  x_q, x_d;
   logic [8:0]  y_q, y_d;
   logic        frame_start_q, frame_start_d;
   logic        sync_error_q, sync_error_d;
   logic        probe_valid_q, probe_valid_d;
   logic [11:0] probe_rgb_q, probe_rgb_d;

   logic        h_fall, v_fall, violation;
   logic        sample_active, probe_hit;
   logic [9:0]  sample_x;
   logic [8:0]  sample_y;
   logic [11:0] rgb;

   assign rgb = {VGA_R, VGA_G, VGA_B};

   // Edge detection and raster counters; nothing moves between strobes.
   always_comb begin
      h_fall    = pix_en & hs_prev_q & ~hSync;
      v_fall    = pix_en & vs_prev_q & ~vSync;
      hs_prev_d = hs_prev_q;
      vs_prev_d = vs_prev_q;
      hcnt_d    = hcnt_q;
      vcnt_d    = vcnt_q;
      if (pix_en) begin
         hs_prev_d = hSync;
         vs_prev_d = vSync;
         hcnt_d    = h_fall ? 10'd0 : hcnt_q + 10'd1;
         if (v_fall) begin
            vcnt_d = 10'd0;
         end else if (h_fall) begin
            vcnt_d = vcnt_q + 10'd1;
         end
      end
   end

   always_comb begin
      violation = 1'b0;
      if (pix_en && (state_q != StSearch)) begin
         violation = (h_fall && (hcnt_q != HLast)) ||
                     (v_fall && (vcnt_q != VLast)) ||
                     (!h_fall && (hcnt_q == HLast));
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StSearch: begin
            if (v_fall) state_d = StAcquire;
         end
         StAcquire: begin
            if (violation)   state_d = StSearch;
            else if (v_fall) state_d = StLocked;
         end
         StLocked: begin
            if (violation) state_d = StSearch;
         end
         default: state_d = StSearch;
      endcase
   end

   // Coordinates describe the sample just taken, so they use the next-state counters.
   always_comb begin
      sample_active = (state_d == StLocked) &&
                      (hcnt_d >= HBegin) && (hcnt_d < HEnd) &&
                      (vcnt_d >= VBegin) && (vcnt_d < VEnd);
      sample_x      = sample_active ? (hcnt_d - HBegin) : 10'd0;
      sample_y      = sample_active ? (vcnt_d[8:0] - YOffset) : 9'd0;
      probe_hit     = pix_en && sample_active &&
                      (sample_x == probe_x) && (sample_y == probe_y);

      active_d      = pix_en ? sample_active : active_q;
      x_d           = pix_en ? sample_x : x_q;
      y_d           = pix_en ? sample_y : y_q;
      probe_rgb_d   = probe_hit ? rgb : probe_rgb_q;
      probe_valid_d = probe_hit;
      frame_start_d = v_fall;
      sync_error_d  = violation;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StSearch;
         hcnt_q        <= 10'd0;
         vcnt_q        <= 10'd0;
         hs_prev_q     <= 1'b1;
         vs_prev_q     <= 1'b1;
         active_q      <= 1'b0;
         x_q           <= 10'd0;
         y_q           <= 9'd0;
         frame_start_q <= 1'b0;
         sync_error_q  <= 1'b0;
         probe_valid_q <= 1'b0;
         probe_rgb_q   <= 12'h000;
      end else begin
         state_q       <= state_d;
         hcnt_q        <= hcnt_d;
         vcnt_q        <= vcnt_d;
         hs_prev_q     <= hs_prev_d;
         vs_prev_q     <= vs_prev_d;
         active_q      <= active_d;
         x_q           <= x_d;
         y_q           <= y_d;
         frame_start_q <= frame_start_d;
         sync_error_q  <= sync_error_d;
         probe_valid_q <= probe_valid_d;
         probe_rgb_q   <= probe_rgb_d;
      end
   end

`ifdef VGA_SINK_CHECKSUM_EN
   logic [15:0] acc_q, acc_d;
   logic [15:0] checksum_q, checksum_d;

   // Every frame edge restarts the accumulator; only a cleanly locked frame publishes it.
   always_comb begin
      acc_d      = acc_q;
      checksum_d = checksum_q;
      if (v_fall) begin
         acc_d = 16'h0000;
         if ((state_q == StLocked) && (state_d == StLocked)) begin
            checksum_d = acc_q;
         end
      end else if (pix_en && sample_active) begin
         acc_d = {acc_q[14:0], acc_q[15]} ^ {4'h0, rgb};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q      <= 16'h0000;
         checksum_q <= 16'h0000;
      end else begin
         acc_q      <= acc_d;
         checksum_q <= checksum_d;
      end
   end

   assign checksum = checksum_q;
`else
   assign checksum = 16'h0000;
`endif

   assign locked      = (state_q == StLocked);
   assign active      = active_q;
   assign x           = x_q;
   assign y           = y_q;
   assign frame_start = frame_start_q;
   assign sync_error  = sync_error_q;
   assign probe_rgb   = probe_rgb_q;
   assign probe_valid = probe_valid_q;

endmodule

// File: tb/tb_vga_sink_decoder.sv
// Directed bench for vga_sink_decoder on a scaled 32x16 raster (active 20x10 at h=6, v=3).
module tb_vga_sink_decoder;

   localparam int HT  = 32;
   localparam int VT  = 16;
   localparam int HS  = 6;
   localparam int VS  = 3;
   localparam int W   = 20;
   localparam int H   = 10;
   localparam int HSW = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        pix_en;
   logic        hSync, vSync;
   logic [3:0]  VGA_R, VGA_G, VGA_B;
   logic [9:0]  probe_x;
   logic [8:0]  probe_y;
   logic        locked, active, frame_start, sync_error, probe_valid;
   logic [9:0]  x;
   logic [8:0]  y;
   logic [11:0] probe_rgb;
   logic [15:0] checksum;

   int checks = 0;
   int errors = 0;
   int fs_cnt = 0, err_cnt = 0, pv_cnt = 0;
   int fs0, err0, pv0;
   logic [15:0] exp_sum;

   typedef struct {
      int   h;
      int   v;
      logic act;
      int   x;
      int   y;
   } vec_t;
   vec_t tbl[11];

   always #5 clk = ~clk;

   vga_sink_decoder #(
      .H_TOTAL(HT), .V_TOTAL(VT), .H_START(HS), .V_START(VS), .WIDTH(W), .HEIGHT(H)
   ) dut (
      .clk(clk), .reset(reset), .pix_en(pix_en), .hSync(hSync), .vSync(vSync),
      .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .probe_x(probe_x), .probe_y(probe_y),
      .locked(locked), .active(active), .x(x), .y(y), .frame_start(frame_start),
      .sync_error(sync_error), .probe_rgb(probe_rgb), .probe_valid(probe_valid),
      .checksum(checksum)
   );

   // Counting every clk makes a stuck pulse count more than once.
   always @(negedge clk) begin
      if (frame_start === 1'b1) fs_cnt  <= fs_cnt + 1;
      if (sync_error === 1'b1)  err_cnt <= err_cnt + 1;
      if (probe_valid === 1'b1) pv_cnt  <= pv_cnt + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic zero_checks(input string p);
      check({p, ".locked"}, 32'(locked), 0);
      check({p, ".active"}, 32'(active), 0);
      check({p, ".x"}, 32'(x), 0);
      check({p, ".y"}, 32'(y), 0);
      check({p, ".frame_start"}, 32'(frame_start), 0);
      check({p, ".sync_error"}, 32'(sync_error), 0);
      check({p, ".probe_rgb"}, 32'(probe_rgb), 0);
      check({p, ".probe_valid"}, 32'(probe_valid), 0);
      check({p, ".checksum"}, 32'(checksum), 0);
   endtask

   function automatic logic [11:0] pix_rgb(input int mode, input int h, input int v);
      logic [31:0] hv, vv;
      hv = h;
      vv = v;
      case (mode)
         1:       return (h == HS && v == VS) ? 12'h001 : 12'h000;
         2:       return (h == HS + W - 1 && v == VS + H - 1) ? 12'hABC : 12'h000;
         3:       return {hv[3:0], vv[3:0], 4'h5};
         default: return 12'h000;
      endcase
   endfunction

`ifdef VGA_SINK_CHECKSUM_EN
   function automatic logic [15:0] sum_model(input int mode);
      logic [15:0] acc;
      acc = 16'h0000;
      for (int v = VS; v < VS + H; v++) begin
         for (int h = HS; h < HS + W; h++) begin
            acc = {acc[14:0], acc[15]} ^ {4'h0, pix_rgb(mode, h, v)};
         end
      end
      return acc;
   endfunction
`endif

   // One pix_en strobe followed by three idle clocks.
   task automatic pix(input logic hs, input logic vs, input logic [11:0] rgb);
      pix_en = 1'b1;
      hSync  = hs;
      vSync  = vs;
      {VGA_R, VGA_G, VGA_B} = rgb;
      @(posedge clk);
      #1;
      pix_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic apply_tbl(input int h, input int v);
      foreach (tbl[i]) begin
         if (tbl[i].h == h && tbl[i].v == v) begin
            check($sformatf("tbl%0d.active", i), 32'(active), 32'(tbl[i].act));
            check($sformatf("tbl%0d.x", i), 32'(x), 32'(tbl[i].x));
            check($sformatf("tbl%0d.y", i), 32'(y), 32'(tbl[i].y));
         end
      end
   endtask

   task automatic send_range(input int v_from, input int h_from, input int v_to,
                             input int mode, input int bad_line, input bit use_tbl);
      for (int v = v_from; v < v_to; v++) begin
         int len;
         len = (v == bad_line) ? HT - 1 : HT;
         for (int h = (v == v_from) ? h_from : 0; h < len; h++) begin
            pix((h < HSW) ? 1'b0 : 1'b1, (v < 2) ? 1'b0 : 1'b1, pix_rgb(mode, h, v));
            if (use_tbl) apply_tbl(h, v);
         end
      end
   endtask

   initial begin
      tbl[0]  = '{6,  3,  1'b1, 0,  0};
      tbl[1]  = '{5,  3,  1'b0, 0,  0};
      tbl[2]  = '{25, 3,  1'b1, 19, 0};
      tbl[3]  = '{26, 3,  1'b0, 0,  0};
      tbl[4]  = '{6,  2,  1'b0, 0,  0};
      tbl[5]  = '{6,  12, 1'b1, 0,  9};
      tbl[6]  = '{6,  13, 1'b0, 0,  0};
      tbl[7]  = '{25, 12, 1'b1, 19, 9};
      tbl[8]  = '{10, 7,  1'b1, 4,  4};
      tbl[9]  = '{0,  0,  1'b0, 0,  0};
      tbl[10] = '{31, 15, 1'b0, 0,  0};

      reset   = 1'b1;
      pix_en  = 1'b0;
      hSync   = 1'b1;
      vSync   = 1'b1;
      {VGA_R, VGA_G, VGA_B} = 12'h000;
      probe_x = 10'(W - 1);
      probe_y = 9'(H - 1);
      repeat (3) @(posedge clk);
      #1;
      zero_checks("rst");
      reset = 1'b0;
      @(posedge clk);
      #1;
      fs0  = fs_cnt;
      err0 = err_cnt;
      pv0  = pv_cnt;

      // Acquire then lock on two ideal frames.
      send_range(0, 0, VT, 2, -1, 1'b0);
      check("f1.locked", 32'(locked), 0);
      send_range(0, 0, VT, 2, -1, 1'b0);
      check("f2.locked", 32'(locked), 1);
      check("f2.frame_starts", fs_cnt - fs0, 2);
      check("f2.sync_errors", err_cnt - err0, 0);
      check("f2.probe_valids", pv_cnt - pv0, 1);
      check("f2.probe_rgb", 32'(probe_rgb), 32'h0ABC);

      pv0 = pv_cnt;
      send_range(0, 0, VT, 3, -1, 1'b1);
      check("f3.probe_valids", pv_cnt - pv0, 1);
      check("f3.probe_rgb", 32'(probe_rgb), 32'h09C5);
`ifdef VGA_SINK_CHECKSUM_EN
      exp_sum = 16'h0ABC;
`else
      exp_sum = 16'h0000;
`endif
      check("f3.checksum", 32'(checksum), 32'(exp_sum));

      // Out-of-range probe column never fires.
      probe_x = 10'(W);
      pv0 = pv_cnt;
      send_range(0, 0, VT, 0, -1, 1'b0);
      check("f4.probe_valids", pv_cnt - pv0, 0);
      check("f4.probe_rgb", 32'(probe_rgb), 32'h09C5);
`ifdef VGA_SINK_CHECKSUM_EN
      exp_sum = sum_model(3);
`else
      exp_sum = 16'h0000;
`endif
      check("f4.checksum", 32'(checksum), 32'(exp_sum));

      send_range(0, 0, VT, 1, -1, 1'b0);
      check("f5.checksum", 32'(checksum), 0);
      send_range(0, 0, VT, 0, -1, 1'b0);
`ifdef VGA_SINK_CHECKSUM_EN
      exp_sum = 16'h0080;
`else
      exp_sum = 16'h0000;
`endif
      check("f6.checksum", 32'(checksum), 32'(exp_sum));
      check("f6.sync_errors", err_cnt - err0, 0);

      // Short line: one error, drop to search, relock after two good frames.
      err0 = err_cnt;
      send_range(0, 0, VT, 0, 5, 1'b0);
      check("f7.sync_errors", err_cnt - err0, 1);
      check("f7.locked", 32'(locked), 0);
      send_range(0, 0, VT, 0, -1, 1'b0);
      check("f8.locked", 32'(locked), 0);
      send_range(0, 0, VT, 0, -1, 1'b0);
      check("f9.locked", 32'(locked), 1);
      check("f9.sync_errors", err_cnt - err0, 1);

      // Reset in the middle of an active line.
      send_range(0, 0, 5, 0, -1, 1'b0);
      for (int h = 0; h < 16; h++) pix((h < HSW) ? 1'b0 : 1'b1, 1'b1, 12'h000);
      check("prerst.active", 32'(active), 1);
      check("prerst.x", 32'(x), 9);
      fs0    = fs_cnt;
      err0   = err_cnt;
      reset  = 1'b1;
      pix_en = 1'b1;
      @(posedge clk);
      #1;
      reset  = 1'b0;
      pix_en = 1'b0;
      zero_checks("midrst");
      repeat (3) @(posedge clk);
      #1;
      for (int h = 17; h < HT; h++) pix(1'b1, 1'b1, 12'h000);
      send_range(6, 0, VT, 0, -1, 1'b0);
      check("postrst.frame_starts", fs_cnt - fs0, 0);
      check("postrst.locked", 32'(locked), 0);
      check("postrst.sync_errors", err_cnt - err0, 0);
      pix(1'b0, 1'b0, 12'h000);
      check("postrst.vedge_frame_start", fs_cnt - fs0, 1);
      check("postrst.vedge_locked", 32'(locked), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
